// File: rtl/bsg_fakeram_arb_pkg.sv
// Shared types and default geometry for the two-port fakeram arbiter.
package bsg_fakeram_arb_pkg;

    localparam int fakeram_els_gp        = 512;
    localparam int fakeram_width_gp      = 64;
    localparam int fakeram_addr_width_gp = 9;

    typedef enum logic {
        e_init,
        e_idle
    } state_e;

endpackage

// File: rtl/bsg_fakeram_arb_rr2.sv
// Two-input round-robin arbiter: combinational grant, pointer flips to the
// other port after every grant so a continuously requesting pair alternates.
module bsg_fakeram_arb_rr2 (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [1:0] req_i,
    output logic [1:0] grant_o
);

    // ptr_r = 1 means port 1 wins a tie
    logic ptr_r;

    always_comb begin
        // NOTE: grant_o is defaulted first so every path assigns it and no latch is inferred.
        grant_o = 2'b00;
        if (req_i == 2'b11) begin
            grant_o = ptr_r ? 2'b10 : 2'b01;
        end else begin
            grant_o = req_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_r <= 1'b0;
        end else if (|grant_o) begin
            // NOTE: non-blocking so the pointer updates from pre-edge values like every other flop.
            ptr_r <= grant_o[0];
        end
    end

endmodule

// File: rtl/bsg_fakeram_512x64_arb.sv
// Two-port arbiter in front of one single-port 512x64 fakeram macro.
// Define BSG_FAKERAM_ARB_INIT_EN to zero the whole macro after reset.
module bsg_fakeram_512x64_arb
    import bsg_fakeram_arb_pkg::*;
#(
    parameter int els_p        = fakeram_els_gp,
    parameter int width_p      = fakeram_width_gp,
    parameter int addr_width_p = fakeram_addr_width_gp
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [1:0]                v_i,
    input  logic [1:0]                w_i,
    input  logic [2*addr_width_p-1:0] addr_i,
    input  logic [2*width_p-1:0]      data_i,
    input  logic [2*width_p-1:0]      mask_i,
    output logic [1:0]                ready_o,
    output logic [width_p-1:0]        data_o,
    output logic [1:0]                v_o,
    input  logic [1:0]                yumi_i,
    output logic                      init_done_o,
    output logic                      mem_ce_o,
    output logic                      mem_we_o,
    output logic [addr_width_p-1:0]   mem_addr_o,
    output logic [width_p-1:0]        mem_wd_o,
    output logic [width_p-1:0]        mem_mask_o,
    input  logic [width_p-1:0]        mem_rd_i
);

    state_e                  state_r, state_n;
    logic [addr_width_p-1:0] init_addr_r;
    logic                    init_active, idle_active;
    logic [1:0]              elig, grant;
    logic [1:0]              rd_pend_r;
    logic [1:0]              v_r;
    logic [width_p-1:0]      resp_r [2];

`ifdef BSG_FAKERAM_ARB_INIT_EN
    localparam state_e reset_state_lp = e_init;
    assign init_done_o = (state_r == e_idle);
`else
    localparam state_e reset_state_lp = e_idle;
    assign init_done_o = 1'b1;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= reset_state_lp;
            init_addr_r <= '0;
        end else begin
            state_r <= state_n;
            if (state_r == e_init) begin
                init_addr_r <= init_addr_r + 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state_r;
        if (state_r == e_init && init_addr_r == addr_width_p'(els_p - 1)) begin
            state_n = e_idle;
        end
    end

    // Gated with reset so ready/ce read as idle while reset is held.
    assign init_active = reset_n_i && (state_r == e_init);
    assign idle_active = reset_n_i && (state_r == e_idle);

    // A pending response blocks its port; a same-cycle yumi does not unblock it.
    assign elig = v_i & ~v_r & {2{idle_active}};

    bsg_fakeram_arb_rr2 rr (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .req_i    (elig),
        .grant_o  (grant)
    );

    assign ready_o = grant;

    always_comb begin
        mem_ce_o   = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_wd_o   = '0;
        mem_mask_o = '0;
        if (init_active) begin
            mem_ce_o   = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = init_addr_r;
            mem_mask_o = '1;
        end else if (grant[1]) begin
            mem_ce_o   = 1'b1;
            mem_we_o   = w_i[1];
            mem_addr_o = addr_i[addr_width_p +: addr_width_p];
            mem_wd_o   = data_i[width_p +: width_p];
            mem_mask_o = mask_i[width_p +: width_p];
        end else if (grant[0]) begin
            mem_ce_o   = 1'b1;
            mem_we_o   = w_i[0];
            mem_addr_o = addr_i[0 +: addr_width_p];
            mem_wd_o   = data_i[0 +: width_p];
            mem_mask_o = mask_i[0 +: width_p];
        end
    end

    // Macro read data appears the cycle after the grant; capture it then.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_pend_r <= 2'b00;
            v_r       <= 2'b00;
            // NOTE: only these two response words are reset, so data_o is 0 out of reset; the macro array itself is never reset here.
            for (int k = 0; k < 2; k++) begin
                resp_r[k] <= '0;
            end
        end else begin
            rd_pend_r <= grant & ~w_i;
            for (int k = 0; k < 2; k++) begin
                if (rd_pend_r[k]) begin
                    resp_r[k] <= mem_rd_i;
                    v_r[k]    <= 1'b1;
                end else if (yumi_i[k]) begin
                    v_r[k] <= 1'b0;
                end
            end
        end
    end

    assign v_o    = v_r;
    assign data_o = (v_r[1] && !v_r[0]) ? resp_r[1] : resp_r[0];

endmodule

// File: tb/tb_bsg_fakeram_512x64_arb.sv
// Scoreboard bench for bsg_fakeram_512x64_arb with a behavioural 512x64 macro.
module tb_bsg_fakeram_512x64_arb;

    localparam int aw = 9;
    localparam int dw = 64;

    logic            clk_i     = 1'b0;
    logic            reset_n_i = 1'b0;
    logic [1:0]      v_i, w_i, ready_o, v_o, yumi_i;
    logic [2*aw-1:0] addr_i;
    logic [2*dw-1:0] data_i, mask_i;
    logic [dw-1:0]   data_o, mem_wd_o, mem_mask_o, mem_rd_i;
    logic            init_done_o, mem_ce_o, mem_we_o;
    logic [aw-1:0]   mem_addr_o;

    int          checks = 0;
    int          errors = 0;
    logic [1:0]  yumi_en;
    logic [1:0]  gnt_seen;
    int          gcount [2];
    logic [63:0] model [512];
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];
    logic [63:0] macro_mem [512];

    always #5 clk_i = ~clk_i;

    bsg_fakeram_512x64_arb dut (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .v_i        (v_i),
        .w_i        (w_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .mask_i     (mask_i),
        .ready_o    (ready_o),
        .data_o     (data_o),
        .v_o        (v_o),
        .yumi_i     (yumi_i),
        .init_done_o(init_done_o),
        .mem_ce_o   (mem_ce_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wd_o   (mem_wd_o),
        .mem_mask_o (mem_mask_o),
        .mem_rd_i   (mem_rd_i)
    );

    // Behavioural single-port macro: masked write, registered read.
    always @(posedge clk_i) begin
        if (mem_ce_o) begin
            if (mem_we_o) macro_mem[mem_addr_o] <= (macro_mem[mem_addr_o] & ~mem_mask_o) | (mem_wd_o & mem_mask_o);
            else          mem_rd_i <= macro_mem[mem_addr_o];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int k, input logic v, input logic w, input logic [aw-1:0] a,
                         input logic [dw-1:0] d, input logic [dw-1:0] m);
        v_i[k]            = v;
        w_i[k]            = w;
        addr_i[k*aw +: aw] = a;
        data_i[k*dw +: dw] = d;
        mask_i[k*dw +: dw] = m;
    endtask

    // One clock: optional grant check, auto-yumi, scoreboard push/pop, advance.
    task automatic cycle(input bit chk = 1'b0, input logic [1:0] exp_rdy = 2'b00, input string tag = "");
        logic [aw-1:0] a;
        #3;
        if (chk) check(tag, ready_o, exp_rdy);
        yumi_i[0] = yumi_en[0] & v_o[0];
        yumi_i[1] = yumi_en[1] & v_o[1] & ~v_o[0];
        #1;
        gnt_seen = v_i & ready_o;
        for (int k = 0; k < 2; k++) begin
            if (gnt_seen[k]) begin
                gcount[k]++;
                a = addr_i[k*aw +: aw];
                if (w_i[k]) model[a] = (model[a] & ~mask_i[k*dw +: dw]) | (data_i[k*dw +: dw] & mask_i[k*dw +: dw]);
                else if (k == 0) q0.push_back(model[a]);
                else q1.push_back(model[a]);
            end
        end
        if (yumi_i[0]) begin
            if (q0.size() == 0) check("rsp0_unexpected", v_o[0], 1'b0);
            else check("rsp0_data", data_o, q0.pop_front());
        end
        if (yumi_i[1]) begin
            if (q1.size() == 0) check("rsp1_unexpected", v_o[1], 1'b0);
            else check("rsp1_data", data_o, q1.pop_front());
        end
        @(posedge clk_i);
        #1;
        yumi_i = 2'b00;
    endtask

    // Each port issues one read at a time from its base and waits for the response.
    task automatic read_back(input int b0, input int n0, input int b1, input int n1);
        int idx [2];
        int nn [2];
        int bb [2];
        int budget;
        idx = '{0, 0};
        nn  = '{n0, n1};
        bb  = '{b0, b1};
        yumi_en = 2'b11;
        budget  = 0;
        while ((idx[0] < nn[0] || idx[1] < nn[1] || q0.size() != 0 || q1.size() != 0) && budget < 200) begin
            drive(0, (idx[0] < nn[0]) && (q0.size() == 0), 1'b0, aw'(bb[0] + idx[0]), '0, '0);
            drive(1, (idx[1] < nn[1]) && (q1.size() == 0), 1'b0, aw'(bb[1] + idx[1]), '0, '0);
            cycle();
            for (int k = 0; k < 2; k++) idx[k] += int'(gnt_seen[k]);
            budget++;
        end
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        check("rb_issued", 64'(idx[0] + idx[1]), 64'(n0 + n1));
        check("rb_drained", 64'(q0.size() + q1.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        v_i = 2'b11; w_i = 2'b00; addr_i = '0; data_i = '0; mask_i = '0;
        yumi_i = 2'b00; yumi_en = 2'b11; gcount = '{0, 0};
        for (int i = 0; i < 512; i++) begin
`ifdef BSG_FAKERAM_ARB_INIT_EN
            model[i] = '0;
`else
            model[i] = 'x;
`endif
        end

        // Reset values, with requests already asserted.
        #12;
        check("rst_ready", ready_o, 2'b00);
        check("rst_v_o", v_o, 2'b00);
        check("rst_data", data_o, 64'd0);
        check("rst_ce", mem_ce_o, 1'b0);
        check("rst_we", mem_we_o, 1'b0);
        check("rst_addr", mem_addr_o, 9'd0);
`ifdef BSG_FAKERAM_ARB_INIT_EN
        check("rst_init_done", init_done_o, 1'b0);
`else
        check("rst_init_done", init_done_o, 1'b1);
`endif
        v_i = 2'b00;
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;

`ifdef BSG_FAKERAM_ARB_INIT_EN
        for (int i = 0; i < 512; i++) begin
            #2;
            check("init_ce", mem_ce_o, 1'b1);
            check("init_we", mem_we_o, 1'b1);
            check("init_addr", mem_addr_o, 64'(i));
            check("init_mask", mem_mask_o, {64{1'b1}});
            check("init_done_low", init_done_o, 1'b0);
            cycle();
        end
        check("init_done_high", init_done_o, 1'b1);
`endif

        // Fairness: both ports write every cycle, pointer starts at port 0.
        gcount = '{0, 0};
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 2; k++) begin
                logic [aw-1:0] a;
                a = aw'((k == 0 ? 32 : 64) + gcount[k]);
                drive(k, 1'b1, 1'b1, a, {32'(k + 1), 32'(a)}, '1);
            end
            cycle(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, "fair_grant");
        end
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        read_back(32, 4, 64, 4);

        // Single write then read on port 0, with exact latency.
        drive(0, 1'b1, 1'b1, 9'h0A5, 64'hDEADBEEF_CAFEF00D, '1);
        #2;
        check("wr_ready", ready_o, 2'b01);
        check("wr_ce", mem_ce_o, 1'b1);
        check("wr_we", mem_we_o, 1'b1);
        check("wr_addr", mem_addr_o, 9'h0A5);
        check("wr_wd", mem_wd_o, 64'hDEADBEEF_CAFEF00D);
        check("wr_mask", mem_mask_o, {64{1'b1}});
        cycle();
        yumi_en[0] = 1'b0;
        drive(0, 1'b1, 1'b0, 9'h0A5, '0, '0);
        #2;
        check("rd_ready", ready_o, 2'b01);
        check("rd_we", mem_we_o, 1'b0);
        cycle();
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        #2;
        check("lat1_v_o", v_o, 2'b00);
        cycle();
        #2;
        check("lat2_v_o", v_o, 2'b01);
        check("lat2_data", data_o, 64'hDEADBEEF_CAFEF00D);
        yumi_en[0] = 1'b1;
        cycle();
        #2;
        check("yumi_clear", v_o, 2'b00);
        cycle();

        // Bit mask.
        drive(0, 1'b1, 1'b1, 9'h010, '1, '1);
        cycle();
        drive(0, 1'b1, 1'b1, 9'h010, '0, 64'h00000000_FFFFFFFF);
        cycle();
        drive(0, 1'b1, 1'b0, 9'h010, '0, '0);
        cycle();
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        cycle();
        #2;
        check("mask_data", data_o, 64'hFFFFFFFF_00000000);
        cycle();

        // Backpressure on port 1 while port 0 keeps being served.
        drive(1, 1'b1, 1'b1, 9'h100, 64'h11111111_11111111, '1);
        cycle();
        drive(1, 1'b1, 1'b1, 9'h101, 64'h22222222_22222222, '1);
        cycle();
        yumi_en[1] = 1'b0;
        drive(1, 1'b1, 1'b0, 9'h100, '0, '0);
        cycle(1'b1, 2'b10, "bp_grant");
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        cycle();
        cycle();
        #2;
        check("bp_v1", v_o[1], 1'b1);
        drive(1, 1'b1, 1'b0, 9'h101, '0, '0);
        gcount[0] = 0;
        for (int i = 0; i < 5; i++) begin
            drive(0, q0.size() == 0, 1'b0, 9'h0A5, '0, '0);
            #2;
            check("bp_blocked", ready_o[1], 1'b0);
            if (!v_o[0]) check("bp_hold", data_o, 64'h11111111_11111111);
            cycle();
        end
        check("bp_p0_served", 64'(gcount[0]), 64'd2);
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 4 && (q0.size() != 0 || v_o[0]); i++) begin
            #2;
            check("bp_blocked_drain", ready_o[1], 1'b0);
            cycle();
        end
        yumi_en[1] = 1'b1;
        #2;
        check("bp_data", data_o, 64'h11111111_11111111);
        cycle();
        #2;
        check("bp_regrant", ready_o, 2'b10);
        cycle();
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 6 && (q0.size() + q1.size()) != 0; i++) cycle();
        check("bp_drained", 64'(q0.size() + q1.size()), 64'd0);

`ifdef BSG_FAKERAM_ARB_INIT_EN
        read_back(0, 1, 511, 1);
`endif

        // Reset in the cycle after a read grant, with a port 1 response pending.
        yumi_en = 2'b01;
        drive(1, 1'b1, 1'b0, 9'h0A5, '0, '0);
        cycle();
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        cycle();
        cycle();
        #2;
        check("rm_v1", v_o[1], 1'b1);
        drive(0, 1'b1, 1'b0, 9'h010, '0, '0);
        cycle(1'b1, 2'b01, "rm_grant");
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        reset_n_i = 1'b0;
        #1;
        check("rm_v_o", v_o, 2'b00);
        check("rm_ce", mem_ce_o, 1'b0);
        check("rm_data", data_o, 64'd0);
        q0.delete();
        q1.delete();
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        yumi_en = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #2;
            check("rm_no_rsp", v_o, 2'b00);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
